// File: rtl/dmem_arbiter_lsu_if.sv
// One requester port of the data-memory arbiter: request fields in, completion out.
// The requester is the master; the arbiter is the slave.
interface dmem_arbiter_lsu_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        is_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, is_unsigned, addr, wdata,
    input  done, err, rdata
  );

  modport slave (
    input  req, we, size, is_unsigned, addr, wdata,
    output done, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter_lsu.sv
// Round-robin two-port front end for a single-port data memory: sequences loads,
// word stores and read-modify-write subword stores, and formats load data.
module dmem_arbiter_lsu #(
  parameter int MEM_ADDR_W = 32,
  parameter int RESET_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dmem_arbiter_lsu_if.slave     a,
  dmem_arbiter_lsu_if.slave     b,
  output logic                  mem_WriteEn,
  output logic                  mem_ReadEn,
  output logic [MEM_ADDR_W-1:0] mem_Addr,
  output logic [31:0]           mem_WriteData,
  input  logic [31:0]           mem_ReadData
);

  typedef enum logic [2:0] {
    IDLE, CHECK, ACCESS, RMW_RD, RMW_WR, RESP
  } state_t;

  state_t      state, state_nxt;
  logic        last_b, grant_b, we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rmw_q, rdata_a_q, rdata_b_q;

  logic        any_req, pick_b, bad_access, result_ld;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [3:0]  byte_mask;
  logic [31:0] load_fmt, merged, result_d;

  assign any_req = a.req | b.req;
  // On a tie the port that was not granted last wins.
  assign pick_b  = b.req & (~a.req | ~last_b);

  always_comb begin
    case (size_q)
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = addr_q[0];
      2'b10:   bad_access = (addr_q[1:0] != 2'b00);
      default: bad_access = 1'b1;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_v = mem_ReadData[7:0];
      2'd1:    byte_v = mem_ReadData[15:8];
      2'd2:    byte_v = mem_ReadData[23:16];
      default: byte_v = mem_ReadData[31:24];
    endcase
    half_v = addr_q[1] ? mem_ReadData[31:16] : mem_ReadData[15:0];
    case (size_q)
      2'b00:   load_fmt = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_fmt = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_fmt = mem_ReadData;
    endcase
  end

  always_comb begin
    byte_mask = (size_q == 2'b00) ? (4'b0001 << addr_q[1:0])
                                  : (addr_q[1] ? 4'b1100 : 4'b0011);
    for (int i = 0; i < 4; i++) begin
      if (!byte_mask[i])
        merged[8*i +: 8] = rmw_q[8*i +: 8];
      else if (size_q == 2'b00 || (i % 2) == 0)
        merged[8*i +: 8] = wdata_q[7:0];
      else
        merged[8*i +: 8] = wdata_q[15:8];
    end
  end

  // The winner's rdata is loaded on the edge entering RESP, so it changes with done.
  assign result_ld = (state == CHECK && bad_access) || state == ACCESS || state == RMW_WR;
  assign result_d  = (state == ACCESS && !we_q) ? load_fmt : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_nxt     = state;
    mem_ReadEn    = 1'b0;
    mem_WriteEn   = 1'b0;
    mem_Addr      = '0;
    mem_WriteData = 32'h0;
    case (state)
      IDLE:   if (any_req) state_nxt = CHECK;
      CHECK: begin
        if (bad_access)                        state_nxt = RESP;
        else if (!we_q || size_q == 2'b10)     state_nxt = ACCESS;
        else                                   state_nxt = RMW_RD;
      end
      ACCESS: begin
        mem_Addr = MEM_ADDR_W'(addr_q[31:2]);
        if (we_q) begin
          mem_WriteEn   = 1'b1;
          mem_WriteData = wdata_q;
        end else begin
          mem_ReadEn = 1'b1;
        end
        state_nxt = RESP;
      end
      RMW_RD: begin
        mem_Addr   = MEM_ADDR_W'(addr_q[31:2]);
        mem_ReadEn = 1'b1;
        state_nxt  = RMW_WR;
      end
      RMW_WR: begin
        mem_Addr      = MEM_ADDR_W'(addr_q[31:2]);
        mem_WriteEn   = 1'b1;
        mem_WriteData = merged;
        state_nxt     = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      last_b    <= (RESET_PRIO == 0);
      grant_b   <= 1'b0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rmw_q     <= 32'h0;
      err_q     <= 1'b0;
      rdata_a_q <= 32'h0;
      rdata_b_q <= 32'h0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_b <= pick_b;
        last_b  <= pick_b;
        we_q    <= pick_b ? b.we          : a.we;
        size_q  <= pick_b ? b.size        : a.size;
        uns_q   <= pick_b ? b.is_unsigned : a.is_unsigned;
        addr_q  <= pick_b ? b.addr        : a.addr;
        wdata_q <= pick_b ? b.wdata       : a.wdata;
      end
      if (state == CHECK)  err_q <= bad_access;
      if (state == RMW_RD) rmw_q <= mem_ReadData;
      if (result_ld) begin
        if (grant_b) rdata_b_q <= result_d;
        else         rdata_a_q <= result_d;
      end
    end
  end

  assign a.done  = (state == RESP) && !grant_b;
  assign b.done  = (state == RESP) &&  grant_b;
  assign a.err   = a.done & err_q;
  assign b.err   = b.done & err_q;
  assign a.rdata = rdata_a_q;
  assign b.rdata = rdata_b_q;

endmodule
